// File: rtl/rv32i_types.sv
// Shared RISC-V core types: LSU state encoding, load/store funct3 codes and
// small helpers for funct3 legality and alignment checks.
package rv32i_types;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HOLD = 2'd2
   } lsu_state_t;

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LD  = 3'b011,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101,
      F3_LWU = 3'b110
   } load_funct3_t;

   typedef enum logic [2:0] {
      F3_SB = 3'b000,
      F3_SH = 3'b001,
      F3_SW = 3'b010,
      F3_SD = 3'b011
   } store_funct3_t;

   // ld, lwu and sd only exist on a 64-bit datapath.
   function automatic logic f3IsLegal(input logic store, input logic [2:0] f3, input logic is64);
      if (store)
         return !f3[2] && ((f3[1:0] != 2'b11) || is64);
      else
         return (f3 != 3'b111) && (((f3 != F3_LD) && (f3 != F3_LWU)) || is64);
   endfunction

   function automatic logic isMisaligned(input logic [1:0] size, input logic [2:0] addrLo);
      case (size)
         2'd1:    return addrLo[0];
         2'd2:    return |addrLo[1:0];
         2'd3:    return |addrLo;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the LSU: byte-enable mask, store data shift
// and load data shift with sign/zero extension.
module lsu_lane_align
   import rv32i_types::*;
#(
   parameter int XLEN = 32
) (
   input  logic                          i_store,
   input  logic [2:0]                    i_funct3,
   input  logic [$clog2(XLEN/8)-1:0]     i_offset,
   input  logic [XLEN-1:0]               i_wdata,
   input  logic [XLEN-1:0]               i_rdata,
   output logic [XLEN/8-1:0]             o_mbe,
   output logic [XLEN-1:0]               o_wdata,
   output logic [XLEN-1:0]               o_rdata
);

   localparam int MBE_W  = XLEN / 8;
   localparam int LANE_W = $clog2(MBE_W);
   localparam bit IS64   = (XLEN == 64);

   logic              w_legal;
   logic [1:0]        w_size;
   logic [LANE_W-1:0] w_off;
   logic [7:0]        w_mask;
   logic [XLEN-1:0]   w_shifted;
   logic              w_sign;

   // Illegal encodings behave as an unshifted full-width access.
   always_comb begin
      w_legal   = f3IsLegal(i_store, i_funct3, IS64);
      w_size    = i_funct3[1:0];
      w_off     = w_legal ? i_offset : '0;
      w_sign    = 1'b0;
      case (w_size)
         2'd0:    w_mask = 8'h01;
         2'd1:    w_mask = 8'h03;
         2'd2:    w_mask = 8'h0F;
         default: w_mask = 8'hFF;
      endcase
      o_mbe     = w_legal ? (w_mask[MBE_W-1:0] << w_off) : '1;
      o_wdata   = i_wdata << {w_off, 3'b000};
      w_shifted = i_rdata >> {w_off, 3'b000};
      o_rdata   = w_shifted;
      if (w_legal && (w_size != 2'd3)) begin
         case (w_size)
            2'd0:    w_sign = w_shifted[7];
            2'd1:    w_sign = w_shifted[15];
            default: w_sign = w_shifted[31];
         endcase
         w_sign = w_sign & ~i_funct3[2];
         for (int i = 0; i < XLEN; i++)
            o_rdata[i] = (i < (8 << w_size)) ? w_shifted[i] : w_sign;
      end
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: request FSM, flush kill bit and response buffer.
// Optional misalignment trap enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu_mem_stage
   import rv32i_types::*;
#(
   parameter  int XLEN   = 32,
   localparam int MBE_W  = XLEN / 8,
   localparam int LANE_W = $clog2(MBE_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_store,
   input  logic [2:0]       req_funct3,
   input  logic [XLEN-1:0]  req_addr,
   input  logic [XLEN-1:0]  req_wdata,
   output logic             data_read,
   output logic             data_write,
   output logic [MBE_W-1:0] data_mbe,
   output logic [XLEN-1:0]  data_addr,
   output logic [XLEN-1:0]  data_wdata,
   input  logic             data_resp,
   input  logic [XLEN-1:0]  data_rdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [XLEN-1:0]  rsp_rdata,
   output logic             rsp_misalign,
   input  logic             flush
);

   lsu_state_t        r_state;
   logic              r_store;
   logic              r_kill;
   logic [2:0]        r_funct3;
   logic [LANE_W-1:0] r_off;

   logic              w_idle;
   logic              w_store;
   logic [2:0]        w_funct3;
   logic [LANE_W-1:0] w_off;
   logic              w_misalign;
   logic [MBE_W-1:0]  w_mbe;
   logic [XLEN-1:0]   w_wdata;
   logic [XLEN-1:0]   w_rdata;

   // One lane aligner serves both phases: incoming request in IDLE, held request in BUSY.
   assign w_idle   = (r_state == IDLE);
   assign w_store  = w_idle ? req_store  : r_store;
   assign w_funct3 = w_idle ? req_funct3 : r_funct3;
   assign w_off    = w_idle ? req_addr[LANE_W-1:0] : r_off;

`ifdef LSU_MISALIGN_CHECK_EN
   assign w_misalign = f3IsLegal(req_store, req_funct3, XLEN == 64) &&
                       isMisaligned(req_funct3[1:0], req_addr[2:0]);
`else
   assign w_misalign = 1'b0;
`endif

   lsu_lane_align #(.XLEN(XLEN)) u_align (
      .i_store  (w_store),
      .i_funct3 (w_funct3),
      .i_offset (w_off),
      .i_wdata  (req_wdata),
      .i_rdata  (data_rdata),
      .o_mbe    (w_mbe),
      .o_wdata  (w_wdata),
      .o_rdata  (w_rdata)
   );

   // A flush during BUSY cannot cancel the memory access, so it is remembered in r_kill.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_store      <= 1'b0;
         r_kill       <= 1'b0;
         r_funct3     <= '0;
         r_off        <= '0;
         req_ready    <= 1'b1;
         data_read    <= 1'b0;
         data_write   <= 1'b0;
         data_mbe     <= '0;
         data_addr    <= '0;
         data_wdata   <= '0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_misalign <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_store   <= req_store;
                  r_funct3  <= req_funct3;
                  r_off     <= req_addr[LANE_W-1:0];
                  r_kill    <= 1'b0;
                  req_ready <= 1'b0;
                  if (w_misalign) begin
                     r_state      <= HOLD;
                     rsp_valid    <= 1'b1;
                     rsp_misalign <= 1'b1;
                     rsp_rdata    <= '0;
                  end else begin
                     r_state    <= BUSY;
                     data_read  <= !req_store;
                     data_write <= req_store;
                     data_mbe   <= w_mbe;
                     data_addr  <= {req_addr[XLEN-1:LANE_W], {LANE_W{1'b0}}};
                     data_wdata <= req_store ? w_wdata : '0;
                  end
               end
            end
            BUSY: begin
               if (data_resp) begin
                  data_read  <= 1'b0;
                  data_write <= 1'b0;
                  if (r_kill || flush) begin
                     r_state   <= IDLE;
                     req_ready <= 1'b1;
                  end else begin
                     r_state   <= HOLD;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= r_store ? '0 : w_rdata;
                  end
               end else if (flush) begin
                  r_kill <= 1'b1;
               end
            end
            HOLD: begin
               if (flush || rsp_ready) begin
                  r_state      <= IDLE;
                  req_ready    <= 1'b1;
                  rsp_valid    <= 1'b0;
                  rsp_rdata    <= '0;
                  rsp_misalign <= 1'b0;
               end
            end
            default: begin
               r_state   <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed testbench for lsu_mem_stage: a 32-bit instance for the main
// scenarios and a 64-bit instance for doubleword lanes.
module tb_lsu_mem_stage;

   logic        clk;
   logic        rst;

   logic        reqValid, reqReady, reqStore, dataRead, dataWrite, dataResp;
   logic        rspValid, rspReady, rspMisalign, flush;
   logic [2:0]  reqFunct3;
   logic [31:0] reqAddr, reqWdata, dataAddr, dataWdata, dataRdata, rspRdata;
   logic [3:0]  dataMbe;

   logic        reqValid64, reqReady64, reqStore64, dataRead64, dataWrite64, dataResp64;
   logic        rspValid64, rspReady64, rspMisalign64, flush64;
   logic [2:0]  reqFunct364;
   logic [63:0] reqAddr64, reqWdata64, dataAddr64, dataWdata64, dataRdata64, rspRdata64;
   logic [7:0]  dataMbe64;

   int testsRun;
   int testsFailed;

   lsu_mem_stage #(.XLEN(32)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(reqValid), .req_ready(reqReady), .req_store(reqStore),
      .req_funct3(reqFunct3), .req_addr(reqAddr), .req_wdata(reqWdata),
      .data_read(dataRead), .data_write(dataWrite), .data_mbe(dataMbe),
      .data_addr(dataAddr), .data_wdata(dataWdata), .data_resp(dataResp),
      .data_rdata(dataRdata), .rsp_valid(rspValid), .rsp_ready(rspReady),
      .rsp_rdata(rspRdata), .rsp_misalign(rspMisalign), .flush(flush)
   );

   lsu_mem_stage #(.XLEN(64)) u_dut64 (
      .clk(clk), .rst(rst),
      .req_valid(reqValid64), .req_ready(reqReady64), .req_store(reqStore64),
      .req_funct3(reqFunct364), .req_addr(reqAddr64), .req_wdata(reqWdata64),
      .data_read(dataRead64), .data_write(dataWrite64), .data_mbe(dataMbe64),
      .data_addr(dataAddr64), .data_wdata(dataWdata64), .data_resp(dataResp64),
      .data_rdata(dataRdata64), .rsp_valid(rspValid64), .rsp_ready(rspReady64),
      .rsp_rdata(rspRdata64), .rsp_misalign(rspMisalign64), .flush(flush64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request for a single cycle; returns in the first BUSY cycle.
   task automatic applyStimulus(input logic store, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
      reqValid  = 1'b1;
      reqStore  = store;
      reqFunct3 = f3;
      reqAddr   = addr;
      reqWdata  = wdata;
      tick();
      reqValid  = 1'b0;
   endtask

   task automatic respond(input logic [31:0] rdata);
      dataResp  = 1'b1;
      dataRdata = rdata;
      tick();
      dataResp  = 1'b0;
   endtask

   task automatic drainRsp();
      rspReady = 1'b1;
      tick();
      rspReady = 1'b0;
   endtask

   task automatic applyStimulus64(input logic store, input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wdata);
      reqValid64  = 1'b1;
      reqStore64  = store;
      reqFunct364 = f3;
      reqAddr64   = addr;
      reqWdata64  = wdata;
      tick();
      reqValid64  = 1'b0;
   endtask

   task automatic respond64(input logic [63:0] rdata);
      dataResp64  = 1'b1;
      dataRdata64 = rdata;
      tick();
      dataResp64  = 1'b0;
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst = 1'b0;
      {reqValid, reqStore, dataResp, rspReady, flush} = '0;
      reqFunct3 = '0; reqAddr = '0; reqWdata = '0; dataRdata = '0;
      {reqValid64, reqStore64, dataResp64, rspReady64, flush64} = '0;
      reqFunct364 = '0; reqAddr64 = '0; reqWdata64 = '0; dataRdata64 = '0;
      tick();
      tick();

      checkOutput("rst_req_ready", 64'(reqReady), 64'h1);
      checkOutput("rst_strobes", 64'({dataRead, dataWrite}), 64'h0);
      checkOutput("rst_mbe", 64'(dataMbe), 64'h0);
      checkOutput("rst_addr_wdata", 64'({dataAddr, dataWdata}), 64'h0);
      checkOutput("rst_rsp", 64'({rspValid, rspMisalign, rspRdata}), 64'h0);
      rst = 1'b1;
      tick();

      // sw with a 3-cycle memory, plus an ignored request while BUSY
      applyStimulus(1'b1, 3'd2, 32'h1000, 32'hDEADBEEF);
      checkOutput("sw_write_c1", 64'(dataWrite), 64'h1);
      checkOutput("sw_read_c1", 64'(dataRead), 64'h0);
      checkOutput("sw_mbe", 64'(dataMbe), 64'hF);
      checkOutput("sw_addr", 64'(dataAddr), 64'h1000);
      checkOutput("sw_wdata", 64'(dataWdata), 64'hDEADBEEF);
      checkOutput("sw_ready_busy", 64'(reqReady), 64'h0);
      reqValid = 1'b1; reqStore = 1'b0; reqAddr = 32'h2000;
      tick();
      reqValid = 1'b0;
      checkOutput("sw_write_c2", 64'(dataWrite), 64'h1);
      tick();
      checkOutput("sw_write_c3", 64'(dataWrite), 64'h1);
      checkOutput("sw_addr_held", 64'(dataAddr), 64'h1000);
      respond(32'h0);
      checkOutput("sw_rsp_valid", 64'(rspValid), 64'h1);
      checkOutput("sw_write_drop", 64'(dataWrite), 64'h0);
      checkOutput("sw_rsp_rdata", 64'(rspRdata), 64'h0);
      drainRsp();
      checkOutput("sw_rsp_done", 64'(rspValid), 64'h0);
      checkOutput("sw_ready_back", 64'(reqReady), 64'h1);
      checkOutput("busy_req_ignored", 64'(dataRead), 64'h0);

      // lb / lbu from the top lane
      applyStimulus(1'b0, 3'd0, 32'h1003, 32'h0);
      checkOutput("lb_read", 64'(dataRead), 64'h1);
      checkOutput("lb_mbe", 64'(dataMbe), 64'h8);
      checkOutput("lb_addr", 64'(dataAddr), 64'h1000);
      respond(32'h80FFFF12);
      checkOutput("lb_rdata", 64'(rspRdata), 64'hFFFFFF80);
      drainRsp();
      applyStimulus(1'b0, 3'd4, 32'h1003, 32'h0);
      respond(32'h80FFFF12);
      checkOutput("lbu_rdata", 64'(rspRdata), 64'h00000080);
      drainRsp();

      // sh into the upper half
      applyStimulus(1'b1, 3'd1, 32'h1002, 32'h0000ABCD);
      checkOutput("sh_mbe", 64'(dataMbe), 64'hC);
      checkOutput("sh_wdata", 64'(dataWdata), 64'hABCD0000);
      checkOutput("sh_addr", 64'(dataAddr), 64'h1000);
      respond(32'h0);
      drainRsp();

      // lh / lhu from the upper half
      applyStimulus(1'b0, 3'd1, 32'h1002, 32'h0);
      respond(32'h80010000);
      checkOutput("lh_rdata", 64'(rspRdata), 64'hFFFF8001);
      drainRsp();
      applyStimulus(1'b0, 3'd5, 32'h1002, 32'h0);
      respond(32'h80010000);
      checkOutput("lhu_rdata", 64'(rspRdata), 64'h00008001);
      drainRsp();

      // flush in BUSY cycle 2, response in cycle 4
      applyStimulus(1'b0, 3'd2, 32'h1000, 32'h0);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("flush_read_kept", 64'(dataRead), 64'h1);
      tick();
      respond(32'h12345678);
      checkOutput("flush_no_rsp", 64'(rspValid), 64'h0);
      checkOutput("flush_ready", 64'(reqReady), 64'h1);

      // flush coinciding with the response
      applyStimulus(1'b0, 3'd2, 32'h1000, 32'h0);
      flush = 1'b1;
      respond(32'h12345678);
      flush = 1'b0;
      checkOutput("flush_resp_no_rsp", 64'(rspValid), 64'h0);
      checkOutput("flush_resp_ready", 64'(reqReady), 64'h1);

      // WB stalls for 5 cycles in HOLD
      applyStimulus(1'b0, 3'd2, 32'h1004, 32'h0);
      respond(32'h12345678);
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold_rdata", 64'(rspRdata), 64'h12345678);
         checkOutput("hold_valid", 64'(rspValid), 64'h1);
         checkOutput("hold_ready", 64'(reqReady), 64'h0);
         tick();
      end
      drainRsp();
      checkOutput("hold_released", 64'(reqReady), 64'h1);

      // flush while holding a response drops it
      applyStimulus(1'b0, 3'd2, 32'h1000, 32'h0);
      respond(32'h0BADF00D);
      checkOutput("hflush_pre", 64'(rspValid), 64'h1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("hflush_valid", 64'(rspValid), 64'h0);
      checkOutput("hflush_ready", 64'(reqReady), 64'h1);

      // sd on a 32-bit datapath is illegal: full-width, unshifted
      applyStimulus(1'b1, 3'd3, 32'h1002, 32'h11223344);
      checkOutput("ill_mbe", 64'(dataMbe), 64'hF);
      checkOutput("ill_wdata", 64'(dataWdata), 64'h11223344);
      checkOutput("ill_addr", 64'(dataAddr), 64'h1000);
      respond(32'h0);
      drainRsp();

      // misaligned lw
      applyStimulus(1'b0, 3'd2, 32'h1002, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
      checkOutput("mis_no_read", 64'(dataRead), 64'h0);
      checkOutput("mis_rsp_valid", 64'(rspValid), 64'h1);
      checkOutput("mis_flag", 64'(rspMisalign), 64'h1);
      checkOutput("mis_rdata", 64'(rspRdata), 64'h0);
`else
      checkOutput("mis_read", 64'(dataRead), 64'h1);
      checkOutput("mis_mbe", 64'(dataMbe), 64'hC);
      respond(32'hAABBCCDD);
      checkOutput("mis_rdata", 64'(rspRdata), 64'h0000AABB);
      checkOutput("mis_flag", 64'(rspMisalign), 64'h0);
`endif
      drainRsp();

      // reset in the middle of BUSY, then a late response
      applyStimulus(1'b0, 3'd2, 32'h1000, 32'h0);
      checkOutput("mrst_busy", 64'(dataRead), 64'h1);
      rst = 1'b0;
      #1;
      checkOutput("mrst_read", 64'(dataRead), 64'h0);
      checkOutput("mrst_ready", 64'(reqReady), 64'h1);
      rst = 1'b1;
      tick();
      respond(32'hCAFEF00D);
      checkOutput("mrst_late_resp", 64'(rspValid), 64'h0);
      checkOutput("mrst_idle", 64'(reqReady), 64'h1);

      // 64-bit datapath
      applyStimulus64(1'b0, 3'd3, 64'h8, 64'h0);
      checkOutput("ld_mbe", 64'(dataMbe64), 64'hFF);
      checkOutput("ld_addr", dataAddr64, 64'h8);
      checkOutput("ld_read", 64'(dataRead64), 64'h1);
      respond64(64'h80000000_12345678);
      checkOutput("ld_rdata", rspRdata64, 64'h80000000_12345678);
      rspReady64 = 1'b1; tick(); rspReady64 = 1'b0;
      applyStimulus64(1'b0, 3'd2, 64'hC, 64'h0);
      checkOutput("lw64_mbe", 64'(dataMbe64), 64'hF0);
      checkOutput("lw64_addr", dataAddr64, 64'h8);
      respond64(64'h80000000_12345678);
      checkOutput("lw64_rdata", rspRdata64, 64'hFFFFFFFF_80000000);
      rspReady64 = 1'b1; tick(); rspReady64 = 1'b0;
      applyStimulus64(1'b0, 3'd6, 64'hC, 64'h0);
      respond64(64'h80000000_12345678);
      checkOutput("lwu64_rdata", rspRdata64, 64'h00000000_80000000);
      rspReady64 = 1'b1; tick(); rspReady64 = 1'b0;
      applyStimulus64(1'b1, 3'd3, 64'h10, 64'h01234567_89ABCDEF);
      checkOutput("sd_mbe", 64'(dataMbe64), 64'hFF);
      checkOutput("sd_wdata", dataWdata64, 64'h01234567_89ABCDEF);
      checkOutput("sd_write", 64'(dataWrite64), 64'h1);
      respond64(64'h0);
      rspReady64 = 1'b1; tick(); rspReady64 = 1'b0;
      checkOutput("sd_ready_back", 64'(reqReady64), 64'h1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
